// File: rtl/issue_queue_mw_pkg.sv
// Shared decode-side types for the issue queue and its hazard checker.
// decode_data_t is the payload stored per entry and presented on the issue slots.
package issue_queue_mw_pkg;

    typedef enum logic [3:0] {
        OP_NOP    = 4'd0,
        OP_ALU    = 4'd1,
        OP_LOAD   = 4'd2,
        OP_STORE  = 4'd3,
        OP_BRANCH = 4'd4,
        OP_MULT   = 4'd5,
        OP_MULTU  = 4'd6,
        OP_DIV    = 4'd7,
        OP_DIVU   = 4'd8,
        OP_MTHI   = 4'd9,
        OP_MTLO   = 4'd10,
        OP_MTC0   = 4'd11
    } decoded_op_t;

    typedef struct packed {
        logic regwrite;
        logic hiwrite;
        logic lowrite;
        logic cp0write;
    } decode_ctl_t;

    typedef struct packed {
        decoded_op_t op;
        decode_ctl_t ctl;
        logic [4:0]  rdst;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [15:0] imm;
    } decode_data_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // The multiply/divide unit is single-occupancy, so two of these never pair.
    function automatic logic is_muldiv(input decoded_op_t op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/issue_queue_mw_issue_pair_check.sv
// Pairing hazard between an older and a younger instruction of one issue group.
// Purely combinational; the top instantiates one per ordered slot pair.
module issue_pair_check
    import issue_queue_mw_pkg::*;
(
    input  decode_data_t i_older,
    input  decode_data_t i_younger,
    output logic         o_hazard
);

    logic w_raw;
    logic w_muldiv;
    logic w_special;

    // r0 is hard-wired, so a write to it never creates a dependency.
    assign w_raw = i_older.ctl.regwrite
                 & (i_older.rdst != REG_ZERO)
                 & ((i_older.rdst == i_younger.ra1) | (i_older.rdst == i_younger.ra2));

    assign w_muldiv  = is_muldiv(i_older.op) & is_muldiv(i_younger.op);

    assign w_special = (i_older.ctl.hiwrite  & i_younger.ctl.hiwrite)
                     | (i_older.ctl.lowrite  & i_younger.ctl.lowrite)
                     | (i_older.ctl.cp0write & i_younger.ctl.cp0write);

    assign o_hazard = w_raw | w_muldiv | w_special;

endmodule

// File: rtl/issue_queue_mw.sv
// In-order multi-wide issue buffer between decode and execute.
// Circular storage with wrap-bit pointers; optional same-cycle pass-through when empty.
module issue_queue_mw
    import issue_queue_mw_pkg::*;
#(
    parameter int DEPTH    = 16,
    parameter int ENQ_W    = 2,
    parameter int ISSUE_W  = 2,
    parameter int PASSTHRU = 1
) (
    input  logic                             clk,
    input  logic                             resetn,
    input  logic                             flush,
    input  logic         [ENQ_W-1:0]         enq_valid,
    input  decode_data_t [ENQ_W-1:0]         enq_data,
    output logic                             enq_ready,
    input  logic         [ISSUE_W-1:0]       opnd_ok,
    output logic         [ISSUE_W-1:0]       issue_valid,
    output decode_data_t [ISSUE_W-1:0]       issue_data,
    output logic         [$clog2(DEPTH):0]   occupancy
);

    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;
    localparam bit PASS_EN = (PASSTHRU != 0);

    logic [PW-1:0]  r_head;
    logic [PW-1:0]  r_tail;
    decode_data_t   r_mem [DEPTH];

    logic [PW-1:0]               w_occ;
    logic                        w_pass;
    logic                        w_accept;
    logic [ISSUE_W-1:0]          w_cand_valid;
    decode_data_t [ISSUE_W-1:0]  w_cand_data;
    logic [ISSUE_W*ISSUE_W-1:0]  w_haz;
    logic [ISSUE_W-1:0]          w_issue;
    logic [PW-1:0]               w_n_iss;
    logic [PW-1:0]               w_n_enq;
    logic [ENQ_W-1:0]            w_wr_en;
    logic [AW-1:0]               w_wr_idx [ENQ_W];

    // Wrap bit makes tail-head span 0..DEPTH without ambiguity.
    assign w_occ     = r_tail - r_head;
    assign occupancy = w_occ;
    assign enq_ready = (PW'(DEPTH) - w_occ) >= PW'(ENQ_W);
    assign w_pass    = PASS_EN & (w_occ == {PW{1'b0}});
    assign w_accept  = enq_ready & ~flush;

    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_cand
        logic [AW-1:0] w_rd_idx;
        assign w_rd_idx = r_head[AW-1:0] + AW'(gi);
        if (gi < ENQ_W) begin : g_pass
            assign w_cand_data[gi]  = w_pass ? enq_data[gi]  : r_mem[w_rd_idx];
            assign w_cand_valid[gi] = w_pass ? enq_valid[gi] : (PW'(gi) < w_occ);
        end else begin : g_nopass
            assign w_cand_data[gi]  = r_mem[w_rd_idx];
            assign w_cand_valid[gi] = ~w_pass & (PW'(gi) < w_occ);
        end
    end

    for (genvar gi = 0; gi < ISSUE_W; gi++) begin : g_row
        for (genvar gj = 0; gj < ISSUE_W; gj++) begin : g_col
            if (gj < gi) begin : g_chk
                issue_pair_check u_pair (
                    .i_older   (w_cand_data[gj]),
                    .i_younger (w_cand_data[gi]),
                    .o_hazard  (w_haz[gi*ISSUE_W+gj])
                );
            end else begin : g_none
                assign w_haz[gi*ISSUE_W+gj] = 1'b0;
            end
        end
    end

    // In-order issue chain: a slot issues only if every older slot issued.
    always_comb begin
        logic w_chain;
        logic w_ok;
        w_issue = {ISSUE_W{1'b0}};
        w_chain = 1'b1;
        w_ok    = 1'b0;
        for (int i = 0; i < ISSUE_W; i++) begin
            w_ok = w_cand_valid[i] & opnd_ok[i] & w_chain;
            for (int j = 0; j < i; j++) begin
                w_ok = w_ok & ~w_haz[i*ISSUE_W+j];
            end
            w_issue[i] = w_ok & ~flush & resetn;
            w_chain    = w_ok;
        end
    end

    assign issue_valid = w_issue;
    assign issue_data  = w_cand_data;

    // Enqueue valids are contiguous and issue is in order, so both counts are popcounts.
    always_comb begin
        w_n_iss = {PW{1'b0}};
        w_n_enq = {PW{1'b0}};
        for (int i = 0; i < ISSUE_W; i++) begin
            w_n_iss = w_n_iss + PW'(w_issue[i]);
        end
        for (int k = 0; k < ENQ_W; k++) begin
            w_n_enq = w_n_enq + PW'(enq_valid[k]);
        end
    end

    // Slots consumed by pass-through skip storage; head still advances past them.
    for (genvar gk = 0; gk < ENQ_W; gk++) begin : g_wr
        assign w_wr_idx[gk] = r_tail[AW-1:0] + AW'(gk);
        assign w_wr_en[gk]  = w_accept & enq_valid[gk] & ~(w_pass & (PW'(gk) < w_n_iss));
    end

    // Head/tail pointers; flush outranks issue and enqueue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head <= {PW{1'b0}};
            r_tail <= {PW{1'b0}};
        end else if (flush) begin
            r_head <= r_tail;
            r_tail <= r_tail;
        end else begin
            r_head <= r_head + w_n_iss;
            if (w_accept) begin
                r_tail <= r_tail + w_n_enq;
            end else begin
                r_tail <= r_tail;
            end
        end
    end

    // Entry storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < ENQ_W; k++) begin
            if (w_wr_en[k]) begin
                r_mem[w_wr_idx[k]] <= enq_data[k];
            end
        end
    end

endmodule

// File: tb/tb_issue_queue_mw.sv
// Directed table-driven bench for issue_queue_mw (DEPTH=16, ENQ_W=2, ISSUE_W=2, PASSTHRU=1).
module tb_issue_queue_mw;
    import issue_queue_mw_pkg::*;

    logic                      clk;
    logic                      resetn;
    logic                      flush;
    logic         [1:0]        enq_valid;
    decode_data_t [1:0]        enq_data;
    logic                      enq_ready;
    logic         [1:0]        opnd_ok;
    logic         [1:0]        issue_valid;
    decode_data_t [1:0]        issue_data;
    logic         [4:0]        occupancy;

    issue_queue_mw #(.DEPTH(16), .ENQ_W(2), .ISSUE_W(2), .PASSTHRU(1)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .flush       (flush),
        .enq_valid   (enq_valid),
        .enq_data    (enq_data),
        .enq_ready   (enq_ready),
        .opnd_ok     (opnd_ok),
        .issue_valid (issue_valid),
        .issue_data  (issue_data),
        .occupancy   (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         fl;
        logic [1:0]   ev;
        decode_data_t d0;
        decode_data_t d1;
        logic [1:0]   ok;
        logic [1:0]   iv;
        logic [1:0]   tm;
        logic [15:0]  t0;
        logic [15:0]  t1;
        logic [4:0]   occ;
        logic         rdy;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_err;

    function automatic decode_data_t mk(decoded_op_t op, logic rw, logic hw, logic lw, logic cw,
                                        logic [4:0] rd, logic [4:0] r1, logic [4:0] r2,
                                        logic [15:0] tag);
        decode_data_t d;
        d.op = op;
        d.ctl.regwrite = rw;
        d.ctl.hiwrite  = hw;
        d.ctl.lowrite  = lw;
        d.ctl.cp0write = cw;
        d.rdst = rd;
        d.ra1  = r1;
        d.ra2  = r2;
        d.imm  = tag;
        return d;
    endfunction

    function automatic decode_data_t alu(logic [15:0] tag, logic [4:0] rd, logic [4:0] r1, logic [4:0] r2);
        return mk(OP_ALU, 1'b1, 1'b0, 1'b0, 1'b0, rd, r1, r2, tag);
    endfunction

    function automatic vec_t mkv(logic fl, logic [1:0] ev, decode_data_t d0, decode_data_t d1,
                                 logic [1:0] ok, logic [1:0] iv, logic [1:0] tm,
                                 logic [15:0] t0, logic [15:0] t1, logic [4:0] occ, logic rdy);
        vec_t v;
        v.fl = fl; v.ev = ev; v.d0 = d0; v.d1 = d1; v.ok = ok;
        v.iv = iv; v.tm = tm; v.t0 = t0; v.t1 = t1; v.occ = occ; v.rdy = rdy;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] want);
        if (got !== want) begin
            n_err++;
            $display("FAIL %s vec %0d: got %0h want %0h", name, idx, got, want);
        end
    endtask

    task automatic check_outputs(input int idx, input vec_t v);
        check("issue_valid", idx, {30'd0, issue_valid}, {30'd0, v.iv});
        check("occupancy",   idx, {27'd0, occupancy},   {27'd0, v.occ});
        check("enq_ready",   idx, {31'd0, enq_ready},   {31'd0, v.rdy});
        if (v.tm[0]) check("issue_data0", idx, {16'd0, issue_data[0].imm}, {16'd0, v.t0});
        if (v.tm[1]) check("issue_data1", idx, {16'd0, issue_data[1].imm}, {16'd0, v.t1});
    endtask

    // Drive just after a rising edge, sample on the falling edge, then step one cycle.
    task automatic apply(input int idx, input vec_t v);
        flush       = v.fl;
        enq_valid   = v.ev;
        enq_data[0] = v.d0;
        enq_data[1] = v.d1;
        opnd_ok     = v.ok;
        @(negedge clk);
        check_outputs(idx, v);
        n_vec++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        decode_data_t nd;
        vec_t         rv;
        n_vec = 0;
        n_err = 0;
        nd = mk(OP_NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 16'hdead);

        // Plain pass-through pairs and the RAW / unit-conflict cases.
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b00, 2'b00, 16'd0, 16'd0, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b11, alu(16'd1, 5'd1, 5'd0, 5'd0), alu(16'd2, 5'd2, 5'd0, 5'd0),
                           2'b11, 2'b11, 2'b11, 16'd1, 16'd2, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b11, alu(16'd3, 5'd3, 5'd0, 5'd0), alu(16'd4, 5'd4, 5'd0, 5'd0),
                           2'b11, 2'b11, 2'b11, 16'd3, 16'd4, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b11, alu(16'd5, 5'd5, 5'd0, 5'd0), alu(16'd6, 5'd6, 5'd5, 5'd0),
                           2'b11, 2'b01, 2'b11, 16'd5, 16'd6, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b01, 2'b01, 16'd6, 16'd0, 5'd1, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b11,
                           mk(OP_MULT, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd1, 5'd2, 16'd7),
                           mk(OP_DIV,  1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd3, 5'd4, 16'd8),
                           2'b11, 2'b01, 2'b11, 16'd7, 16'd8, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b01, 2'b01, 16'd8, 16'd0, 5'd1, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b11, alu(16'd9, 5'd9, 5'd0, 5'd0), alu(16'd10, 5'd10, 5'd0, 5'd0),
                           2'b10, 2'b00, 2'b11, 16'd9, 16'd10, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b01, 2'b01, 2'b11, 16'd9, 16'd10, 5'd2, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b01, 2'b01, 16'd10, 16'd0, 5'd1, 1'b1));
        // Non-hazards: write to r0, and a match on an instruction that does not write.
        vecs.push_back(mkv(1'b0, 2'b11, mk(OP_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 16'd40),
                           alu(16'd41, 5'd7, 5'd0, 5'd0), 2'b11, 2'b11, 2'b11, 16'd40, 16'd41, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b11, mk(OP_STORE, 1'b0, 1'b0, 1'b0, 1'b0, 5'd7, 5'd1, 5'd2, 16'd42),
                           alu(16'd43, 5'd8, 5'd7, 5'd0), 2'b11, 2'b11, 2'b11, 16'd42, 16'd43, 5'd0, 1'b1));
        // RAW via ra2, then hi / lo / cp0 / pure mul-div conflicts.
        vecs.push_back(mkv(1'b0, 2'b11, alu(16'd44, 5'd12, 5'd0, 5'd0), alu(16'd45, 5'd13, 5'd0, 5'd12),
                           2'b11, 2'b01, 2'b11, 16'd44, 16'd45, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b01, 2'b01, 16'd45, 16'd0, 5'd1, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b11, mk(OP_MTHI, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd3, 5'd0, 16'd46),
                           mk(OP_MTHI, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd4, 5'd0, 16'd47),
                           2'b11, 2'b01, 2'b11, 16'd46, 16'd47, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b01, 2'b01, 16'd47, 16'd0, 5'd1, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b11, mk(OP_MTLO, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd3, 5'd0, 16'd48),
                           mk(OP_MTLO, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd4, 5'd0, 16'd49),
                           2'b11, 2'b01, 2'b11, 16'd48, 16'd49, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b01, 2'b01, 16'd49, 16'd0, 5'd1, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b11, mk(OP_MTC0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd3, 5'd0, 16'd50),
                           mk(OP_MTC0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd4, 5'd0, 16'd51),
                           2'b11, 2'b01, 2'b11, 16'd50, 16'd51, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b01, 2'b01, 16'd51, 16'd0, 5'd1, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b11, mk(OP_MULTU, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd1, 5'd2, 16'd52),
                           mk(OP_DIVU, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd3, 5'd4, 16'd53),
                           2'b11, 2'b01, 2'b11, 16'd52, 16'd53, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b01, 2'b01, 16'd53, 16'd0, 5'd1, 1'b1));
        // Fill to 16 with operands unavailable; the head pair stays visible throughout.
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mkv(1'b0, 2'b11, alu(16'(100 + 2*k), 5'd1, 5'd0, 5'd0),
                               alu(16'(101 + 2*k), 5'd2, 5'd0, 5'd0), 2'b00, 2'b00, 2'b11,
                               16'd100, 16'd101, 5'(2*k), 1'b1));
        end
        // Full: enqueue ignored while two issue; at 14 enqueue and issue together.
        vecs.push_back(mkv(1'b0, 2'b11, alu(16'd190, 5'd1, 5'd0, 5'd0), alu(16'd191, 5'd2, 5'd0, 5'd0),
                           2'b11, 2'b11, 2'b11, 16'd100, 16'd101, 5'd16, 1'b0));
        vecs.push_back(mkv(1'b0, 2'b11, alu(16'd116, 5'd1, 5'd0, 5'd0), alu(16'd117, 5'd2, 5'd0, 5'd0),
                           2'b11, 2'b11, 2'b11, 16'd102, 16'd103, 5'd14, 1'b1));
        for (int k = 0; k < 7; k++) begin
            vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b11, 2'b11,
                               16'(104 + 2*k), 16'(105 + 2*k), 5'(14 - 2*k), 1'b1));
        end
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b00, 2'b00, 16'd0, 16'd0, 5'd0, 1'b1));
        // Seven entries with the tail wrapped past the array end, then flush with enqueues.
        for (int k = 0; k < 3; k++) begin
            vecs.push_back(mkv(1'b0, 2'b11, alu(16'(200 + 2*k), 5'd1, 5'd0, 5'd0),
                               alu(16'(201 + 2*k), 5'd2, 5'd0, 5'd0), 2'b00, 2'b00, 2'b11,
                               16'd200, 16'd201, 5'(2*k), 1'b1));
        end
        vecs.push_back(mkv(1'b0, 2'b01, alu(16'd206, 5'd1, 5'd0, 5'd0), nd, 2'b00, 2'b00, 2'b11,
                           16'd200, 16'd201, 5'd6, 1'b1));
        vecs.push_back(mkv(1'b1, 2'b11, alu(16'd207, 5'd1, 5'd0, 5'd0), alu(16'd208, 5'd2, 5'd0, 5'd0),
                           2'b11, 2'b00, 2'b11, 16'd200, 16'd201, 5'd7, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b00, 2'b00, 16'd0, 16'd0, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b11, alu(16'd210, 5'd1, 5'd0, 5'd0), alu(16'd211, 5'd2, 5'd0, 5'd0),
                           2'b11, 2'b11, 2'b11, 16'd210, 16'd211, 5'd0, 1'b1));
        vecs.push_back(mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b00, 2'b00, 16'd0, 16'd0, 5'd0, 1'b1));

        resetn    = 1'b0;
        flush     = 1'b0;
        enq_valid = 2'b00;
        enq_data  = {nd, nd};
        opnd_ok   = 2'b00;
        #12;
        rv = mkv(1'b0, 2'b00, nd, nd, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 5'd0, 1'b1);
        check_outputs(-1, rv);
        n_vec++;
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) apply(i, vecs[i]);

        // Async reset mid-fill at occupancy 9.
        for (int k = 0; k < 4; k++) begin
            apply(1000 + k, mkv(1'b0, 2'b11, alu(16'(300 + 2*k), 5'd1, 5'd0, 5'd0),
                                alu(16'(301 + 2*k), 5'd2, 5'd0, 5'd0), 2'b00, 2'b00, 2'b11,
                                16'd300, 16'd301, 5'(2*k), 1'b1));
        end
        apply(1004, mkv(1'b0, 2'b01, alu(16'd308, 5'd1, 5'd0, 5'd0), nd, 2'b00, 2'b00, 2'b00,
                        16'd0, 16'd0, 5'd8, 1'b1));
        enq_valid = 2'b00;
        opnd_ok   = 2'b00;
        #2;
        check("occ_before_reset", 1005, {27'd0, occupancy}, 32'd9);
        n_vec++;
        #1;
        resetn = 1'b0;
        #1;
        rv = mkv(1'b0, 2'b00, nd, nd, 2'b00, 2'b00, 2'b00, 16'd0, 16'd0, 5'd0, 1'b1);
        check_outputs(1006, rv);
        n_vec++;
        @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        apply(1007, mkv(1'b0, 2'b11, alu(16'd320, 5'd1, 5'd0, 5'd0), alu(16'd321, 5'd2, 5'd0, 5'd0),
                        2'b11, 2'b11, 2'b11, 16'd320, 16'd321, 5'd0, 1'b1));
        apply(1008, mkv(1'b0, 2'b00, nd, nd, 2'b11, 2'b00, 2'b00, 16'd0, 16'd0, 5'd0, 1'b1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
